// File: rtl/dcache_blocking_miss_ctrl_pkg.sv
// Shared types for the blocking dcache miss sequencer.
// Geometry: 32KB, 4-way, 32B lines. That gives 256 sets per way and a
// 64-bit data RAM holding 4 beats per line. Address split is
// {tag[18:0], set[7:0], line offset[4:0]}.
package dcache_blocking_miss_ctrl_pkg;

  localparam int BEATS_N    = 4;    // beats per line (RAM_DAT_LINE_N)
  localparam int SETS_N     = 256;  // sets per way (RAM_TAG_N)
  localparam int WAYS_N     = 4;
  localparam int LINE_OFF_W = 5;
  localparam int SET_W      = $clog2(SETS_N);
  localparam int BEAT_W     = $clog2(BEATS_N);
  localparam int TAG_W      = 32 - SET_W - LINE_OFF_W;

  typedef logic [31:0]       addr_t;
  typedef logic [WAYS_N-1:0] ways_t;
  typedef logic [TAG_W-1:0]  cache_line_tag_t;
  // Index of a line within one way, i.e. the set number.
  typedef logic [SET_W-1:0]  cache_line_off_t;
  // Beat (bank) within a line.
  typedef logic [BEAT_W-1:0] ram_dat_line_t;

  typedef struct packed {
    cache_line_off_t set;
    ram_dat_line_t   beat;
  } ram_dat_addr_t;

  typedef struct packed {
    logic            v;
    logic            d;
    cache_line_tag_t tag;
  } tag_ent_t;

  typedef struct packed {
    logic  wr;
    addr_t addr;
  } mem_cmd_t;

  typedef enum logic [2:0] {
    IDLE, WB_CMD, WB_RD, WB_DAT, FILL_CMD, FILL_DAT, TAG_WR, DONE
  } miss_state_t;

  // Line-aligned memory address from a tag and a set.
  function automatic addr_t line_addr(cache_line_tag_t tag, cache_line_off_t set);
    return {tag, set, {LINE_OFF_W{1'b0}}};
  endfunction

endpackage

// File: rtl/dcache_blocking_miss_ctrl.sv
// Miss sequencer for the blocking dcache.
// It accepts one miss at a time. If the victim is dirty, the victim line is
// read out of the data RAM beat by beat and written back to memory. The new
// line is then fetched and written into the data RAM. Finally the tag entry
// is written and fill_done is pulsed so the pipeline can replay.
// Ports:
//   miss_*     : miss request from the lookup pipeline (valid/ready)
//   fill_done  : one-cycle completion pulse
//   ram_dat_*  : data RAM port, 64-bit, address {set, beat}; read data
//                arrives one cycle after the read
//   ram_tag_*  : tag RAM write port, wdat {valid, dirty, tag}
//   mem_cmd_*  : line command to memory (wr=1 writeback, wr=0 fill)
//   mem_wdat_* : writeback beats (valid/ready)
//   mem_rdat_* : fill beats, no backpressure
module dcache_blocking_miss_ctrl
  import dcache_blocking_miss_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_vld,
  output logic        miss_rdy,
  input  logic [31:0] miss_addr,
  input  logic [3:0]  miss_way,
  input  logic        miss_dirty,
  input  logic [18:0] miss_vtag,
  output logic        fill_done,
  output logic        ram_dat_en,
  output logic        ram_dat_wen,
  output logic [3:0]  ram_dat_way,
  output logic [9:0]  ram_dat_addr,
  output logic [63:0] ram_dat_wdat,
  input  logic [63:0] ram_dat_rdat,
  output logic        ram_tag_en,
  output logic [3:0]  ram_tag_way,
  output logic [7:0]  ram_tag_addr,
  output logic [20:0] ram_tag_wdat,
  output logic        mem_cmd_vld,
  input  logic        mem_cmd_rdy,
  output logic        mem_cmd_wr,
  output logic [31:0] mem_cmd_addr,
  output logic        mem_wdat_vld,
  input  logic        mem_wdat_rdy,
  output logic [63:0] mem_wdat,
  input  logic        mem_rdat_vld,
  input  logic [63:0] mem_rdat
);

  localparam ram_dat_line_t BEAT_LAST = ram_dat_line_t'(BEATS_N - 1);

  miss_state_t     state, state_next;
  cache_line_tag_t req_tag;
  cache_line_off_t req_set;
  ways_t           req_way;
  logic            req_dirty;
  cache_line_tag_t req_vtag;
  ram_dat_line_t   beat;
  logic [63:0]     hold_dat;
  // High on the first WB_DAT cycle, when the RAM read data is still on
  // ram_dat_rdat rather than in hold_dat.
  logic            hold_first;

  ram_dat_addr_t   dat_addr;
  tag_ent_t        tag_ent;
  mem_cmd_t        cmd;

  // The byte offset within the line plays no part in a line-granular miss.
  logic unused_addr_off;
  assign unused_addr_off = ^miss_addr[LINE_OFF_W-1:0];

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:     if (miss_vld) state_next = miss_dirty ? WB_CMD : FILL_CMD;
      WB_CMD:   if (mem_cmd_rdy) state_next = WB_RD;
      WB_RD:    state_next = WB_DAT;
      WB_DAT:   if (mem_wdat_rdy) state_next = (beat == BEAT_LAST) ? FILL_CMD : WB_RD;
      FILL_CMD: if (mem_cmd_rdy) state_next = FILL_DAT;
      FILL_DAT: if (mem_rdat_vld && beat == BEAT_LAST) state_next = TAG_WR;
      TAG_WR:   state_next = DONE;
      DONE:     state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // Captured request, beat counter and writeback holding register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_tag    <= '0;
      req_set    <= '0;
      req_way    <= '0;
      req_dirty  <= 1'b0;
      req_vtag   <= '0;
      beat       <= '0;
      hold_dat   <= '0;
      hold_first <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (miss_vld) begin
            req_tag   <= miss_addr[31 -: TAG_W];
            req_set   <= miss_addr[LINE_OFF_W +: SET_W];
            req_way   <= miss_way;
            req_dirty <= miss_dirty;
            req_vtag  <= miss_vtag;
          end
          beat <= '0;
        end
        WB_CMD, FILL_CMD: beat <= '0;
        WB_RD: hold_first <= 1'b1;
        WB_DAT: begin
          if (hold_first) begin
            hold_dat   <= ram_dat_rdat;
            hold_first <= 1'b0;
          end
          // Increment wraps 3->0 exactly when leaving for FILL_CMD.
          if (mem_wdat_rdy) beat <= beat + 1'b1;
        end
        FILL_DAT: if (mem_rdat_vld) beat <= beat + 1'b1;
        default: ;
      endcase
    end
  end

  // Output logic
  always_comb begin
    miss_rdy     = 1'b0;
    fill_done    = 1'b0;
    ram_dat_en   = 1'b0;
    ram_dat_wen  = 1'b0;
    dat_addr     = '0;
    ram_dat_wdat = '0;
    ram_tag_en   = 1'b0;
    ram_tag_addr = '0;
    tag_ent      = '0;
    cmd          = '0;
    mem_cmd_vld  = 1'b0;
    mem_wdat_vld = 1'b0;
    mem_wdat     = '0;
    unique case (state)
      IDLE: miss_rdy = 1'b1;
      WB_CMD: begin
        mem_cmd_vld = 1'b1;
        cmd         = '{wr: 1'b1, addr: line_addr(req_vtag, req_set)};
      end
      WB_RD: begin
        ram_dat_en = 1'b1;
        dat_addr   = '{set: req_set, beat: beat};
      end
      WB_DAT: begin
        mem_wdat_vld = 1'b1;
        // Forward the RAM output on the first cycle so a ready memory takes
        // the beat without an extra cycle.
        mem_wdat     = hold_first ? ram_dat_rdat : hold_dat;
      end
      FILL_CMD: begin
        mem_cmd_vld = 1'b1;
        cmd         = '{wr: 1'b0, addr: line_addr(req_tag, req_set)};
      end
      FILL_DAT: begin
        if (mem_rdat_vld) begin
          ram_dat_en   = 1'b1;
          ram_dat_wen  = 1'b1;
          dat_addr     = '{set: req_set, beat: beat};
          ram_dat_wdat = mem_rdat;
        end
      end
      TAG_WR: begin
        ram_tag_en   = 1'b1;
        ram_tag_addr = req_set;
        tag_ent      = '{v: 1'b1, d: 1'b0, tag: req_tag};
      end
      DONE: fill_done = 1'b1;
      default: ;
    endcase
  end

  assign ram_dat_addr = dat_addr;
  assign ram_dat_way  = ram_dat_en ? req_way : '0;
  assign ram_tag_way  = ram_tag_en ? req_way : '0;
  assign ram_tag_wdat = tag_ent;
  assign mem_cmd_wr   = cmd.wr;
  assign mem_cmd_addr = cmd.addr;

  // The victim way select must be one-hot when a miss is accepted.
  a_way_onehot: assert property (@(posedge clk) disable iff (!rst_n)
    (miss_vld && miss_rdy) |-> $onehot(miss_way));

endmodule

// File: tb/tb_dcache_blocking_miss_ctrl.sv
module tb_dcache_blocking_miss_ctrl;
  import dcache_blocking_miss_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        miss_vld = 1'b0;
  logic        miss_rdy;
  logic [31:0] miss_addr = '0;
  logic [3:0]  miss_way = '0;
  logic        miss_dirty = 1'b0;
  logic [18:0] miss_vtag = '0;
  logic        fill_done;
  logic        ram_dat_en, ram_dat_wen;
  logic [3:0]  ram_dat_way;
  logic [9:0]  ram_dat_addr;
  logic [63:0] ram_dat_wdat;
  logic [63:0] ram_dat_rdat;
  logic        ram_tag_en;
  logic [3:0]  ram_tag_way;
  logic [7:0]  ram_tag_addr;
  logic [20:0] ram_tag_wdat;
  logic        mem_cmd_vld;
  logic        mem_cmd_rdy = 1'b0;
  logic        mem_cmd_wr;
  logic [31:0] mem_cmd_addr;
  logic        mem_wdat_vld;
  logic        mem_wdat_rdy = 1'b0;
  logic [63:0] mem_wdat;
  logic        mem_rdat_vld = 1'b0;
  logic [63:0] mem_rdat = '0;

  always #5 clk = ~clk;

  dcache_blocking_miss_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .miss_vld(miss_vld), .miss_rdy(miss_rdy), .miss_addr(miss_addr),
    .miss_way(miss_way), .miss_dirty(miss_dirty), .miss_vtag(miss_vtag),
    .fill_done(fill_done),
    .ram_dat_en(ram_dat_en), .ram_dat_wen(ram_dat_wen), .ram_dat_way(ram_dat_way),
    .ram_dat_addr(ram_dat_addr), .ram_dat_wdat(ram_dat_wdat), .ram_dat_rdat(ram_dat_rdat),
    .ram_tag_en(ram_tag_en), .ram_tag_way(ram_tag_way), .ram_tag_addr(ram_tag_addr),
    .ram_tag_wdat(ram_tag_wdat),
    .mem_cmd_vld(mem_cmd_vld), .mem_cmd_rdy(mem_cmd_rdy), .mem_cmd_wr(mem_cmd_wr),
    .mem_cmd_addr(mem_cmd_addr),
    .mem_wdat_vld(mem_wdat_vld), .mem_wdat_rdy(mem_wdat_rdy), .mem_wdat(mem_wdat),
    .mem_rdat_vld(mem_rdat_vld), .mem_rdat(mem_rdat)
  );

  int total = 0;
  int bad   = 0;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int oh2idx(input logic [3:0] oh);
    case (oh)
      4'b0010: return 1;
      4'b0100: return 2;
      4'b1000: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic logic [63:0] init_val(input int w, input int i);
    return {16'hC0DE, 16'(w), 16'h5A5A, 16'(i)};
  endfunction

  // ---------------- data RAM model (physical storage) ----------------
  logic [63:0] phys [4][1024];
  logic        ram_init_req = 1'b0;
  logic        pl_en = 1'b0;
  int          pl_way = 0;
  logic [9:0]  pl_addr = '0;
  logic [63:0] pl_dat = '0;

  always @(posedge clk) begin
    if (ram_init_req) begin
      for (int w = 0; w < 4; w++)
        for (int i = 0; i < 1024; i++) phys[w][i] <= init_val(w, i);
    end else if (pl_en) begin
      phys[pl_way][pl_addr] <= pl_dat;
    end
    if (ram_dat_en) begin
      if (ram_dat_wen) phys[oh2idx(ram_dat_way)][ram_dat_addr] <= ram_dat_wdat;
      else             ram_dat_rdat <= phys[oh2idx(ram_dat_way)][ram_dat_addr];
    end
  end

  // Reference contents the bench expects the RAM to hold.
  logic [63:0] ref_ram [4][1024];

  // ---------------- monitor ----------------
  logic [32:0] obs_cmd[$];
  logic [63:0] obs_wb[$];
  logic [13:0] obs_rd[$];
  logic [77:0] obs_dw[$];
  logic [32:0] obs_tw[$];
  int   stab_err = 0, way_err = 0, wb_at_fill = 0, fill_seen = 0, cmd_cnt = 0;
  bit   cmd_pend = 0, wd_pend = 0;
  logic [32:0] cmd_prev = '0;
  logic [63:0] wd_prev = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      cmd_pend = 0; wd_pend = 0; cmd_cnt = 0;
    end else begin
      if (cmd_pend && (!mem_cmd_vld || {mem_cmd_wr, mem_cmd_addr} !== cmd_prev)) stab_err++;
      if (wd_pend && (!mem_wdat_vld || mem_wdat !== wd_prev)) stab_err++;
      if (mem_cmd_vld && mem_cmd_rdy) begin
        obs_cmd.push_back({mem_cmd_wr, mem_cmd_addr});
        if (!mem_cmd_wr) begin
          fill_seen++;
          wb_at_fill = obs_wb.size();
        end
        cmd_cnt = 0;
      end else if (mem_cmd_vld) cmd_cnt++;
      else cmd_cnt = 0;
      cmd_pend = mem_cmd_vld && !mem_cmd_rdy;
      cmd_prev = {mem_cmd_wr, mem_cmd_addr};
      if (mem_wdat_vld && mem_wdat_rdy) obs_wb.push_back(mem_wdat);
      wd_pend = mem_wdat_vld && !mem_wdat_rdy;
      wd_prev = mem_wdat;
      if (ram_dat_en && !ram_dat_wen) obs_rd.push_back({ram_dat_way, ram_dat_addr});
      if (ram_dat_en && ram_dat_wen) obs_dw.push_back({ram_dat_way, ram_dat_addr, ram_dat_wdat});
      if (ram_tag_en) obs_tw.push_back({ram_tag_way, ram_tag_addr, ram_tag_wdat});
      if (!ram_dat_en && ram_dat_way != 4'd0) way_err++;
      if (!ram_tag_en && ram_tag_way != 4'd0) way_err++;
    end
  end

  // ---------------- memory model ----------------
  int  cmd_delay = 0, cmd_pct = 100, wdat_pct = 100, gap_max = 0;
  bit  gap_rand = 0, wdat_toggle = 0, stray_en = 0;
  logic [63:0] cur_fill [4];
  int  fill_taken = 0, fill_beat = 0, gap_cnt = 0;
  bit  fill_active = 0, wtog = 0;

  function automatic int pick_gap();
    return gap_rand ? int'($urandom_range(0, gap_max)) : gap_max;
  endfunction

  always begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      fill_active  = 0;
      fill_taken   = fill_seen;
      mem_rdat_vld = 1'b0;
      mem_cmd_rdy  = 1'b0;
      mem_wdat_rdy = 1'b0;
    end else begin
      if (fill_taken != fill_seen) begin
        fill_taken  = fill_seen;
        fill_active = 1;
        fill_beat   = 0;
        gap_cnt     = pick_gap();
      end
      mem_rdat_vld = 1'b0;
      mem_rdat     = '0;
      if (fill_active) begin
        if (gap_cnt == 0) begin
          mem_rdat_vld = 1'b1;
          mem_rdat     = cur_fill[fill_beat];
          fill_beat++;
          if (fill_beat == 4) fill_active = 0;
          gap_cnt = pick_gap();
        end else gap_cnt--;
      end else if (stray_en && $urandom_range(0, 3) == 0) begin
        mem_rdat_vld = 1'b1;
        mem_rdat     = {$urandom, $urandom};
      end
      mem_cmd_rdy  = (cmd_cnt >= cmd_delay) && ($urandom_range(1, 100) <= cmd_pct);
      wtog         = ~wtog;
      mem_wdat_rdy = wdat_toggle ? wtog : ($urandom_range(1, 100) <= wdat_pct);
    end
  end

  task automatic set_mem(input int d, input int cp, input int wp, input bit tog,
                         input int gm, input bit gr, input bit st);
    cmd_delay = d; cmd_pct = cp; wdat_pct = wp; wdat_toggle = tog;
    gap_max = gm; gap_rand = gr; stray_en = st;
  endtask

  task automatic preload(input int w, input logic [9:0] a, input logic [63:0] d);
    @(negedge clk);
    pl_en = 1'b1; pl_way = w; pl_addr = a; pl_dat = d;
    ref_ram[w][a] = d;
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  function automatic logic [86:0] ctrl_outs();
    return {miss_rdy, fill_done, ram_dat_en, ram_dat_wen, ram_dat_way, ram_dat_addr,
            ram_tag_en, ram_tag_way, ram_tag_addr, ram_tag_wdat,
            mem_cmd_vld, mem_cmd_wr, mem_cmd_addr, mem_wdat_vld};
  endfunction

  logic [86:0] exp_idle;

  task automatic check_idle(input string tag);
    check_val({tag, "_ctrl"}, ctrl_outs(), exp_idle);
    check_val({tag, "_data"}, {ram_dat_wdat, mem_wdat}, 128'd0);
  endtask

  // One complete miss; called and returns at a negedge.
  task automatic do_miss(input logic [31:0] a, input logic [3:0] w, input logic d,
                         input logic [18:0] vt, input bit hold, input int exp_lat,
                         input logic [63:0] fill_base);
    int b_cmd = obs_cmd.size(), b_rd = obs_rd.size(), b_wb = obs_wb.size();
    int b_dw = obs_dw.size(), b_tw = obs_tw.size();
    int s0 = stab_err, w0 = way_err;
    int n = 0, viol = 0, lat = -1, wi = oh2idx(w);
    logic [7:0]  set = a[12:5];
    logic [18:0] tag = a[31:13];
    logic [1:0]  bb;
    for (int b = 0; b < 4; b++)
      cur_fill[b] = (fill_base != 0) ? fill_base + 64'(b) : {$urandom, $urandom};
    while (!miss_rdy && n < 1000) begin @(negedge clk); n++; end
    check_val("rdy_wait", n < 1000, 1'b1);
    miss_vld = 1'b1; miss_addr = a; miss_way = w; miss_dirty = d; miss_vtag = vt;
    n = 0;
    while (n < 3000) begin
      @(negedge clk);
      n++;
      if (n == 1 && !hold) miss_vld = 1'b0;
      if (fill_done) begin lat = n; break; end
      if (miss_rdy) viol++;
    end
    check_val("done_seen", lat > 0, 1'b1);
    if (exp_lat >= 0) check_val("latency", lat, exp_lat);
    check_val("busy_rdy", viol, 0);
    check_val("cmd_cnt", obs_cmd.size() - b_cmd, d ? 2 : 1);
    if (d) begin
      check_val("wb_cmd", obs_cmd[b_cmd], {1'b1, vt, set, 5'b0});
      check_val("fill_cmd", obs_cmd[b_cmd + 1], {1'b0, tag, set, 5'b0});
      check_val("wb_before_fill", wb_at_fill - b_wb, 4);
    end else begin
      check_val("fill_cmd", obs_cmd[b_cmd], {1'b0, tag, set, 5'b0});
    end
    check_val("rd_cnt", obs_rd.size() - b_rd, d ? 4 : 0);
    check_val("wb_cnt", obs_wb.size() - b_wb, d ? 4 : 0);
    check_val("dw_cnt", obs_dw.size() - b_dw, 4);
    for (int i = 0; i < 4; i++) begin
      bb = 2'(i);
      if (d) begin
        check_val("wb_rd", obs_rd[b_rd + i], {w, set, bb});
        check_val("wb_dat", obs_wb[b_wb + i], ref_ram[wi][{set, bb}]);
      end
      check_val("fill_wr", obs_dw[b_dw + i], {w, set, bb, cur_fill[i]});
      ref_ram[wi][{set, bb}] = cur_fill[i];
    end
    check_val("tw_cnt", obs_tw.size() - b_tw, 1);
    check_val("tag_wr", obs_tw[b_tw], {w, set, 1'b1, 1'b0, tag});
    check_val("stable", stab_err - s0, 0);
    check_val("way_zero", way_err - w0, 0);
    $display("miss addr=%h way=%b dirty=%0d vtag=%h latency=%0d", a, w, d, vt, lat);
    @(negedge clk);
    check_val("rdy_after_done", miss_rdy, 1'b1);
  endtask

  initial begin
    int n;
    int b_dw;
    exp_idle = {1'b1, 86'd0};
    for (int w = 0; w < 4; w++)
      for (int i = 0; i < 1024; i++) ref_ram[w][i] = init_val(w, i);
    ram_init_req = 1'b1;
    repeat (2) @(posedge clk);
    #1 ram_init_req = 1'b0;
    check_idle("reset");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk);
    check_idle("post_reset");

    // Clean miss, zero-wait memory: fill_done 7 cycles after acceptance.
    set_mem(0, 100, 100, 0, 0, 0, 0);
    do_miss(32'h0000_1240, 4'b0010, 1'b0, 19'h0, 0, 7, 64'hA0);

    // Dirty miss from preloaded victim line; 9 extra cycles at zero wait.
    for (int b = 0; b < 4; b++) preload(2, {8'h05, 2'(b)}, 64'h11 * 64'(b + 1));
    do_miss({19'h12345, 8'h05, 5'h0}, 4'b0100, 1'b1, 19'h7FFFF, 0, 16, 64'h0);

    // Backpressure: command ready held off 5 cycles, writeback ready toggling.
    set_mem(5, 100, 100, 1, 0, 0, 0);
    do_miss({19'h0ABCD, 8'hFE, 5'h0}, 4'b1000, 1'b1, 19'h1234F, 0, -1, 64'h0);

    // Gapped fill with stray beats around it; idle strays must not write.
    set_mem(0, 100, 100, 0, 3, 0, 1);
    do_miss({19'h00777, 8'h33, 5'h1F}, 4'b0001, 1'b0, 19'h0, 0, -1, 64'h0);
    b_dw = obs_dw.size();
    repeat (20) @(negedge clk);
    check_val("stray_idle", obs_dw.size() - b_dw, 0);

    // Busy: miss_vld held through the whole miss, next one taken right after.
    set_mem(1, 80, 80, 0, 1, 1, 0);
    do_miss({19'h4_0001, 8'h10, 5'h0}, 4'b0010, 1'b1, 19'h3_0003, 1, -1, 64'h0);
    do_miss({19'h4_0002, 8'h11, 5'h0}, 4'b0100, 1'b0, 19'h0, 0, -1, 64'h0);

    // Reset in the middle of a fill after two beats have been written.
    set_mem(0, 100, 100, 0, 2, 0, 0);
    for (int b = 0; b < 4; b++) cur_fill[b] = 64'hDEAD_0000 + 64'(b);
    b_dw = obs_dw.size();
    miss_vld = 1'b1; miss_addr = {19'h5_5555, 8'h44, 5'h0}; miss_way = 4'b1000;
    miss_dirty = 1'b0; miss_vtag = '0;
    @(negedge clk) miss_vld = 1'b0;
    n = 0;
    while (obs_dw.size() - b_dw < 2 && n < 200) begin @(negedge clk); n++; end
    check_val("rst_two_beats", obs_dw.size() - b_dw, 2);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1 check_idle("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    // Partial line was written; model reflects those two beats.
    for (int i = 0; i < 2; i++) ref_ram[3][{8'h44, 2'(i)}] = cur_fill[i];
    @(negedge clk);
    check_idle("after_abort");
    set_mem(0, 100, 100, 0, 0, 0, 0);
    do_miss({19'h5_5555, 8'h44, 5'h0}, 4'b1000, 1'b1, 19'h6_6666, 0, 16, 64'h0);

    // Randomized misses with random memory timing.
    for (int k = 0; k < 25; k++) begin
      set_mem($urandom_range(0, 3), $urandom_range(50, 100), $urandom_range(40, 100),
              1'b0, $urandom_range(0, 2), 1'b1, $urandom_range(0, 1) == 1);
      do_miss($urandom, 4'b0001 << $urandom_range(0, 3), 1'($urandom_range(0, 1)),
              19'($urandom), 0, -1, 64'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
